rr_arb_16: RTL and testbench

//   Round-robin arbiter sharing one resource among 16 requesters.

---
 rtl/arb_pkg.sv | 17 +
 rtl/dec_4x16.sv | 18 +
 rtl/rr_arb_16.sv | 93 +++++++++
 tb/tb_rr_arb_16.sv | 130 +++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 16-way round-robin arbiter.
//   ST_IDLE / ST_GRANT : FSM encodings
//   IDX_W              : width of a requester index
//   N_REQ              : number of requesters
package arb_pkg;

  localparam logic        ST_IDLE  = 1'b0;
  localparam logic        ST_GRANT = 1'b1;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned N_REQ    = 16;

  typedef enum logic {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT
  } state_t;

endpackage

// File: rtl/dec_4x16.sv
// 4-to-16 one-hot decoder with enable.
//   en  : when 0 the output is all-zero
//   in  : index to decode
//   out : one-hot of in, gated by en
module dec_4x16
  import arb_pkg::*;
(
  input  logic             en,
  input  logic [IDX_W-1:0] in,
  output logic [N_REQ-1:0] out
);

  always_comb begin
    out = '0;
    if (en) out = N_REQ'(1) << in;
  end

endmodule

// File: rtl/rr_arb_16.sv
// Round-robin arbiter: one exclusive owner among 16 requesters, held until
// the owner drops its request, the hold limit expires, or en falls.
//   clk, rst : clock and synchronous active-high reset
//   en       : 0 blocks new grants and drops the active one
//   req      : level-sensitive request vector
//   gnt      : one-hot grant, zero when gnt_vld=0
//   gnt_idx  : current/last owner
//   gnt_vld  : a grant is active
//   timeout  : one-cycle pulse when the hold limit forced the release
module rr_arb_16
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [IDX_W-1:0]    winner;
  logic                owner_req;
  logic                hold_end;

  // First set bit scanning p, p+1, ... p+15 (mod 16).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   pos;
    dbl = {r, r} >> p;
    rot = dbl[N_REQ-1:0];
    pos = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) pos = IDX_W'(i);
    end
    return p + pos;
  endfunction

  assign winner    = rr_pick(req, ptr);
  assign owner_req = req[gnt_idx];
  assign hold_end  = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // Arbitration FSM; all outputs except gnt are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && |req) begin
            gnt_idx  <= winner;
            gnt_vld  <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          if (!owner_req || !en || hold_end) begin
            gnt_vld <= 1'b0;
            state   <= IDLE;
            ptr     <= gnt_idx + IDX_W'(1);
            // Only flag timeout when nothing else would have released the grant.
            timeout <= owner_req && en;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dec_4x16 u_dec (
    .en  (gnt_vld),
    .in  (gnt_idx),
    .out (gnt)
  );

endmodule

// File: tb/tb_rr_arb_16.sv
module tb_rr_arb_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_vld;
  logic        timeout;

  typedef struct {
    string       tag;
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        vld;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  rr_arb_16 #(.MAX_HOLD(4), .HOLD_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  // Push the expected post-edge outputs, advance one clock, then pop and compare.
  task automatic cyc(input string tag, input logic [15:0] e_gnt, input logic [3:0] e_idx,
                     input logic e_vld, input logic e_to);
    exp_t e;
    logic [21:0] obs;
    logic [21:0] want;
    e.tag = tag; e.gnt = e_gnt; e.idx = e_idx; e.vld = e_vld; e.to = e_to;
    q.push_back(e);
    @(posedge clk);
    #1;
    e    = q.pop_front();
    obs  = {gnt, gnt_idx, gnt_vld, timeout};
    want = {e.gnt, e.idx, e.vld, e.to};
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s: observed gnt=%h idx=%0d vld=%b to=%b, expected gnt=%h idx=%0d vld=%b to=%b",
                e.tag, gnt, gnt_idx, gnt_vld, timeout, e.gnt, e.idx, e.vld, e.to);
  endtask

  task automatic grant_run(input string tag, input logic [3:0] idx);
    for (int k = 0; k < 4; k++) cyc(tag, 16'h1 << idx, idx, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; req = 16'h0000;
    cyc("reset", 16'h0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Idle with no requests
    for (int i = 0; i < 5; i++) cyc("idle_noreq", 16'h0, 4'd0, 1'b0, 1'b0);

    // Lowest index from ptr=0, then the other requester after a gap
    req = 16'h0021;
    cyc("grant0", 16'h0001, 4'd0, 1'b1, 1'b0);
    req = 16'h0020;
    cyc("release0", 16'h0, 4'd0, 1'b0, 1'b0);
    cyc("grant5", 16'h0020, 4'd5, 1'b1, 1'b0);
    req = 16'h0000;
    cyc("release5", 16'h0, 4'd5, 1'b0, 1'b0);
    cyc("idle_gap", 16'h0, 4'd5, 1'b0, 1'b0);

    // Two constant requesters with ptr=6: 15,0,15,0 with timeouts and wrap
    req = 16'h8001;
    grant_run("hold15a", 4'd15);
    cyc("tmo15a", 16'h0, 4'd15, 1'b0, 1'b1);
    grant_run("hold0a", 4'd0);
    cyc("tmo0a", 16'h0, 4'd0, 1'b0, 1'b1);
    grant_run("hold15b", 4'd15);
    cyc("tmo15b", 16'h0, 4'd15, 1'b0, 1'b1);
    grant_run("hold0b", 4'd0);
    cyc("tmo0b", 16'h0, 4'd0, 1'b0, 1'b1);
    req = 16'h0000;
    cyc("tmo_pulse_end", 16'h0, 4'd0, 1'b0, 1'b0);

    // en=0 drops owner 3 without timeout; ptr becomes 4
    req = 16'h0008;
    cyc("grant3", 16'h0008, 4'd3, 1'b1, 1'b0);
    en = 1'b0;
    cyc("en_drop", 16'h0, 4'd3, 1'b0, 1'b0);
    cyc("en_low_idle", 16'h0, 4'd3, 1'b0, 1'b0);
    en = 1'b1; req = 16'h0018;
    cyc("ptr4_grant4", 16'h0010, 4'd4, 1'b1, 1'b0);
    req = 16'h0000;
    cyc("release4", 16'h0, 4'd4, 1'b0, 1'b0);

    // rst mid-grant returns ptr to 0
    req = 16'h0080;
    cyc("grant7", 16'h0080, 4'd7, 1'b1, 1'b0);
    rst = 1'b1; req = 16'h0081;
    cyc("rst_mid_grant", 16'h0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc("post_rst_grant0", 16'h0001, 4'd0, 1'b1, 1'b0);
    req = 16'h0000;
    cyc("release0c", 16'h0, 4'd0, 1'b0, 1'b0);

    // Owner drops on the last hold cycle: normal release, no timeout
    req = 16'h0002;
    cyc("grant1", 16'h0002, 4'd1, 1'b1, 1'b0);
    cyc("hold1_1", 16'h0002, 4'd1, 1'b1, 1'b0);
    cyc("hold1_2", 16'h0002, 4'd1, 1'b1, 1'b0);
    cyc("hold1_3", 16'h0002, 4'd1, 1'b1, 1'b0);
    req = 16'h0000;
    cyc("drop_at_limit", 16'h0, 4'd1, 1'b0, 1'b0);
    cyc("idle_end", 16'h0, 4'd1, 1'b0, 1'b0);

    // Lone requester re-wins after its own release
    req = 16'h0002;
    cyc("lone_rewin", 16'h0002, 4'd1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
